// File: rtl/sha256_block_streamer_pkg.sv
// sha256_block_streamer_pkg: shared FSM states, padding constants and block-count helper
package sha256_block_streamer_pkg;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
   localparam logic [31:0] PAD_WORD = 32'h8000_0000;
   localparam int WORDS_PER_BLOCK = 16;
   // S message words plus pad word plus two length words, rounded up to whole blocks
   function automatic logic [8:0] calc_num_blocks(input logic [11:0] s);
      logic [12:0] t;
      t = {1'b0, s} + 13'd18;
      return t[12:4];
   endfunction
endpackage

// File: rtl/sha256_pad_word.sv
// sha256_pad_word: combinational selection of the padded-stream word and its flags for index w
module sha256_pad_word
   import sha256_block_streamer_pkg::*;
(
   input  logic [12:0] w,
   input  logic [11:0] s,
   input  logic [8:0]  n,
   input  logic [31:0] data,
   output logic [31:0] word,
   output logic        block_last,
   output logic        last
);
   logic [12:0] last_w;
   logic [16:0] bit_len;
   // message data, pad marker, low length word or zero depending on position
   always_comb begin
      last_w = 13'(n) * 13'(WORDS_PER_BLOCK) - 13'd1;
      bit_len = {s, 5'b0};
      word = w < {1'b0, s} ? data : w == {1'b0, s} ? PAD_WORD : w == last_w ? {15'b0, bit_len} : '0;
      block_last = w[3:0] == 4'hF;
      last = w == last_w;
   end
endmodule

// File: rtl/sha256_block_streamer.sv
// sha256_block_streamer: fetches a message from memory and streams it as SHA-256 padded blocks
module sha256_block_streamer
   import sha256_block_streamer_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [11:0]       size,
   input  logic [ADDR_W-1:0] message_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_read_data,
   output logic [31:0]       out_word,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_block_last,
   output logic              out_last,
   output logic [8:0]        num_blocks,
   output logic              busy,
   output logic              done
);
   state_t            state, state_nx;
   logic [12:0]       w, w_inc, pw;
   logic [11:0]       s_q, ps;
   logic [8:0]        pn;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       p_word;
   logic              p_bl, p_last, hs, load;
   sha256_pad_word u_pad (
      .w          (pw),
      .s          (ps),
      .n          (pn),
      .data       (mem_read_data),
      .word       (p_word),
      .block_last (p_bl),
      .last       (p_last)
   );
   // in IDLE the pad selector sees the incoming request so an empty message can emit word 0 at once
   always_comb begin
      hs = out_valid && out_ready;
      w_inc = w + 13'd1;
      pw = state == IDLE ? '0 : w;
      ps = state == IDLE ? size : s_q;
      pn = state == IDLE ? calc_num_blocks(size) : num_blocks;
      load = (state == IDLE && start && size == '0) || state == WAIT || (state == EMIT && !out_valid);
      busy = state == FETCH || state == WAIT || state == EMIT;
      done = state == DONE;
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? (size == '0 ? EMIT : FETCH) : IDLE;
         FETCH:   state_nx = WAIT;
         WAIT:    state_nx = EMIT;
         EMIT:    state_nx = !hs ? EMIT : out_last ? DONE : w_inc < {1'b0, s_q} ? FETCH : EMIT;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   // request latching, word index, memory address and output word register
   always_ff @(posedge clk) begin
      if (reset) begin
         s_q <= '0;
         addr_q <= '0;
         w <= '0;
         num_blocks <= '0;
         mem_addr <= '0;
         out_word <= '0;
         out_valid <= 1'b0;
         out_block_last <= 1'b0;
         out_last <= 1'b0;
      end else begin
         if (state == IDLE && start) begin
            s_q <= size;
            addr_q <= message_addr;
            num_blocks <= pn;
            w <= '0;
            if (size != '0) mem_addr <= message_addr;
         end
         if (load) begin
            out_word <= p_word;
            out_valid <= 1'b1;
            out_block_last <= p_bl;
            out_last <= p_last;
         end else if (hs) begin
            out_valid <= 1'b0;
            out_block_last <= 1'b0;
            out_last <= 1'b0;
            if (!out_last) begin
               w <= w_inc;
               if (w_inc < {1'b0, s_q}) mem_addr <= addr_q + ADDR_W'(w_inc);
            end
         end
      end
   end
endmodule

// File: tb/tb_sha256_block_streamer.sv
// tb_sha256_block_streamer: scoreboard bench for the padded block streamer
module tb_sha256_block_streamer;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic [11:0] size = '0;
   logic [15:0] message_addr = '0, mem_addr;
   logic [31:0] mem_read_data = '0, out_word;
   logic        out_valid, out_block_last, out_last, busy, done;
   logic [8:0]  num_blocks;
   typedef struct {logic [31:0] word; logic bl; logic last;} exp_t;
   exp_t        exp_q[$];
   int          n_checks = 0, n_err = 0, hs_cnt = 0, rmode = 0;
   logic        held = 1'b0, done_due = 1'b0;
   logic [31:0] held_word = '0;
   sha256_block_streamer dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .size           (size),
      .message_addr   (message_addr),
      .mem_addr       (mem_addr),
      .mem_read_data  (mem_read_data),
      .out_word       (out_word),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_block_last (out_block_last),
      .out_last       (out_last),
      .num_blocks     (num_blocks),
      .busy           (busy),
      .done           (done)
   );
   always #5 clk = ~clk;
   // memory model: one-cycle read latency, mem[a] = a + 1
   always @(posedge clk) mem_read_data <= {16'b0, mem_addr} + 32'd1;
   // consumer: always ready, random ready, or stalled
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask
   // monitor: pops the scoreboard on every handshake, checks stall stability and done pulse
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset) begin
         held = 1'b0;
         done_due = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_word", out_word, held_word);
         end
         if (done || done_due) chk("done_pulse", 32'(done), 32'(done_due));
         done_due = out_valid && out_ready && out_last;
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL extra_word: got %h, none expected", out_word);
            end else begin
               e = exp_q.pop_front();
               chk("word", out_word, e.word);
               chk("block_last", 32'(out_block_last), 32'(e.bl));
               chk("last", 32'(out_last), 32'(e.last));
            end
         end
         held = out_valid && !out_ready;
         held_word = out_word;
      end
   end
   task automatic push_msg(input int s, input int a, input int nb);
      exp_t e;
      logic [15:0] ad;
      for (int w = 0; w < 16 * nb; w++) begin
         ad = 16'(a + w);
         e.word = w < s ? {16'b0, ad} + 32'd1 : w == s ? 32'h8000_0000 : w == 16 * nb - 1 ? 32'(s * 32) : 32'h0;
         e.bl = (w % 16) == 15;
         e.last = w == 16 * nb - 1;
         exp_q.push_back(e);
      end
   endtask
   task automatic issue(input int s, input int a, input int nb);
      push_msg(s, a, nb);
      @(posedge clk);
      #1;
      start = 1'b1;
      size = 12'(s);
      message_addr = 16'(a);
      @(posedge clk);
      #1;
      start = 1'b0;
      size = 12'hABC;
      message_addr = 16'h5555;
      chk("num_blocks", 32'(num_blocks), 32'(nb));
      chk("busy", 32'(busy), 32'd1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask
   task automatic wait_done(input int budget);
      int c;
      c = 0;
      while (done !== 1'b1 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (done !== 1'b1) begin
         n_checks++;
         n_err++;
         $display("FAIL timeout: done not seen within %0d cycles", budget);
      end else chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask
   int tbl [9][4] = '{
      '{0, 'h0000, 1, 0}, '{13, 'h0000, 1, 0}, '{14, 'h0000, 2, 0},
      '{5, 'h0200, 1, 1}, '{3, 'hFFFE, 1, 1}, '{29, 'h0010, 2, 1},
      '{12, 'h0300, 1, 1}, '{4093, 'h0000, 256, 0}, '{4095, 'h0000, 257, 0}
   };
   initial begin
      int c;
      start = 1'b1;
      size = 12'd5;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_num_blocks", 32'(num_blocks), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_out_word", out_word, 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         rmode = tbl[i][3];
         issue(tbl[i][0], tbl[i][1], tbl[i][2]);
         wait_done(20000);
      end
      rmode = 0;
      hs_cnt = 0;
      issue(20, 'h40, 2);
      c = 0;
      while (hs_cnt < 7 && c < 500) begin
         @(negedge clk);
         c++;
      end
      rmode = 2;
      @(negedge clk);
      c = 0;
      while (!out_valid && c < 50) begin
         @(negedge clk);
         c++;
      end
      chk("w7_word", out_word, 32'h48);
      @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_word", out_word, 32'd0);
      chk("mid_rst_flags", {30'b0, out_block_last, out_last}, 32'd0);
      chk("mid_rst_busy_done", {30'b0, busy, done}, 32'd0);
      chk("mid_rst_num_blocks", 32'(num_blocks), 32'd0);
      chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
      rmode = 0;
      issue(20, 'h40, 2);
      wait_done(2000);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
